// File: rtl/alu_issuer.sv
// Single-issue ALU sequencer: decodes a MIPS-style instruction, drives an external
// ALU for two cycles, and holds the captured result until the consumer takes it.
package ALUType;
  typedef logic [31:0] op_t;
  typedef enum logic [2:0] {
    AND       = 3'd0,
    OR        = 3'd1,
    XOR       = 3'd2,
    ADD       = 3'd3,
    SUB       = 3'd4,
    LESS_THAN = 3'd5
  } cmd_t;
endpackage

module alu_issuer
  import ALUType::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  op_t         rs_val,
  input  op_t         rt_val,
  output cmd_t        alu_cmd,
  output op_t         alu_a,
  output op_t         alu_b,
  input  op_t         alu_out,
  input  logic        alu_overflow,
  input  logic        alu_zero,
  output logic        res_valid,
  input  logic        res_ready,
  output op_t         res_data,
  output logic        res_zero,
  output logic        res_overflow,
  output logic        res_trap,
  output logic        res_illegal
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  typedef struct packed {
    logic legal;
    logic trap;
    cmd_t cmd;
    op_t  b;
  } dec_t;

  state_t state_q, state_d;
  cmd_t   cmd_q;
  op_t    a_q, b_q;
  logic   trap_q;
  op_t    res_data_q;
  logic   res_zero_q, res_ovf_q, res_trap_q, res_ill_q;

  dec_t        dec;
  logic [5:0]  opcode, funct;
  logic [15:0] imm;
  op_t         imm_sx, imm_zx;
  logic        accept;
  logic [9:0]  unused_bits;

  assign opcode      = instr[31:26];
  assign funct       = instr[5:0];
  assign imm         = instr[15:0];
  assign imm_sx      = {{16{imm[15]}}, imm};
  assign imm_zx      = {16'h0000, imm};
  assign unused_bits = instr[25:16];

  // Operand A is always rs; only B and the command depend on the encoding.
  always_comb begin
    dec.legal = 1'b1;
    dec.trap  = 1'b0;
    dec.cmd   = AND;
    dec.b     = rt_val;
    unique case (opcode)
      6'h00: begin
        unique case (funct)
          6'h20: begin dec.cmd = ADD; dec.trap = 1'b1; end
          6'h21: dec.cmd = ADD;
          6'h22: begin dec.cmd = SUB; dec.trap = 1'b1; end
          6'h23: dec.cmd = SUB;
          6'h24: dec.cmd = AND;
          6'h25: dec.cmd = OR;
          6'h27: dec.cmd = XOR;   // ALU's XOR slot computes nor
          6'h2A: dec.cmd = LESS_THAN;
          default: dec.legal = 1'b0;
        endcase
      end
      6'h04: dec.cmd = SUB;
      6'h08: begin dec.cmd = ADD; dec.b = imm_sx; dec.trap = 1'b1; end
      6'h09: begin dec.cmd = ADD; dec.b = imm_sx; end
      6'h0A: begin dec.cmd = LESS_THAN; dec.b = imm_sx; end
      6'h0C: begin dec.cmd = AND; dec.b = imm_zx; end
      6'h0D: begin dec.cmd = OR;  dec.b = imm_zx; end
      default: dec.legal = 1'b0;
    endcase
  end

  assign instr_ready = (state_q == IDLE);
  assign accept      = instr_ready && instr_valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = dec.legal ? ISSUE : DONE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Result registers are cleared on accept so an illegal op reports all zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q      <= AND;
      a_q        <= '0;
      b_q        <= '0;
      trap_q     <= 1'b0;
      res_data_q <= '0;
      res_zero_q <= 1'b0;
      res_ovf_q  <= 1'b0;
      res_trap_q <= 1'b0;
      res_ill_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          cmd_q      <= dec.cmd;
          a_q        <= rs_val;
          b_q        <= dec.b;
          trap_q     <= dec.trap;
          res_data_q <= '0;
          res_zero_q <= 1'b0;
          res_ovf_q  <= 1'b0;
          res_trap_q <= 1'b0;
          res_ill_q  <= ~dec.legal;
        end
        ISSUE: begin
          res_ovf_q  <= alu_overflow;
          res_trap_q <= alu_overflow & trap_q;
        end
        WAIT: begin
          res_data_q <= alu_out;
          res_zero_q <= alu_zero;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    alu_cmd = AND;
    alu_a   = '0;
    alu_b   = '0;
    if (state_q == ISSUE || state_q == WAIT) begin
      alu_cmd = cmd_q;
      alu_a   = a_q;
      alu_b   = b_q;
    end
  end

  assign res_valid    = (state_q == DONE);
  assign res_data     = res_data_q;
  assign res_zero     = res_zero_q;
  assign res_overflow = res_ovf_q;
  assign res_trap     = res_trap_q;
  assign res_illegal  = res_ill_q;

endmodule

// File: tb/tb_alu_issuer.sv
// Directed bench for alu_issuer with a behavioural ALU (registered out/zero,
// combinational overflow) and hand-computed expected results.
module tb_alu_issuer;
  import ALUType::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid, instr_ready, res_valid, res_ready;
  logic [31:0] instr;
  op_t         rs_val, rt_val, alu_a, alu_b, alu_out, res_data;
  cmd_t        alu_cmd;
  logic        alu_overflow, alu_zero, res_zero, res_overflow, res_trap, res_illegal;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_issuer dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rs_val(rs_val), .rt_val(rt_val),
    .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero), .res_overflow(res_overflow),
    .res_trap(res_trap), .res_illegal(res_illegal)
  );

  function automatic op_t alu_f(cmd_t c, op_t a, op_t b);
    case (c)
      ADD:       return a + b;
      SUB:       return a - b;
      AND:       return a & b;
      OR:        return a | b;
      XOR:       return ~(a | b);
      LESS_THAN: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default:   return 32'd0;
    endcase
  endfunction

  op_t sum_c, dif_c;
  assign sum_c = alu_a + alu_b;
  assign dif_c = alu_a - alu_b;
  assign alu_overflow =
    (alu_cmd == ADD) ? ((alu_a[31] == alu_b[31]) && (sum_c[31] != alu_a[31])) :
    (alu_cmd == SUB) ? ((alu_a[31] != alu_b[31]) && (dif_c[31] != alu_a[31])) : 1'b0;

  always @(posedge clk) begin
    alu_out  <= alu_f(alu_cmd, alu_a, alu_b);
    alu_zero <= (alu_f(alu_cmd, alu_a, alu_b) == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    op_t         rs, rt;
    op_t         data;
    logic        zero, ovf, trap, ill;
  } vec_t;

  // Issue one op, keep instr_valid high with junk while busy, check latency and result.
  task automatic run_vec(input vec_t v);
    int cyc;
    @(negedge clk);
    instr = v.instr; rs_val = v.rs; rt_val = v.rt;
    instr_valid = 1'b1; res_ready = 1'b0;
    chk({v.name, ".rdy"}, 32'(instr_ready), 32'd1);
    @(negedge clk);
    instr = 32'h0000_0022; rs_val = 32'hA5A5_A5A5; rt_val = 32'h5A5A_5A5A;
    cyc = 1;
    if (!v.ill) chk({v.name, ".alu_a"}, alu_a, v.rs);
    else        chk({v.name, ".alu_idle"}, {27'd0, alu_cmd, 2'b00} | alu_a | alu_b, 32'd0);
    while (!res_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk({v.name, ".lat"}, 32'(cyc), v.ill ? 32'd1 : 32'd3);
    chk({v.name, ".data"}, res_data, v.data);
    chk({v.name, ".flags"}, {28'd0, res_zero, res_overflow, res_trap, res_illegal},
        {28'd0, v.zero, v.ovf, v.trap, v.ill});
    instr_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({v.name, ".back_idle"}, {30'd0, instr_ready, res_valid}, 32'd2);
  endtask

  vec_t vecs[$];
  vec_t va;
  op_t  held;

  initial begin
    rst = 1'b1; instr_valid = 1'b0; res_ready = 1'b0;
    instr = '0; rs_val = '0; rt_val = '0;

    vecs.push_back('{"add",   32'h0000_0020, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 1, 1, 0});
    vecs.push_back('{"addu",  32'h0000_0021, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 1, 0, 0});
    vecs.push_back('{"andi",  32'h3000_FFFF, 32'h1234_5678, 32'h0, 32'h0000_5678, 0, 0, 0, 0});
    vecs.push_back('{"addiu", 32'h2400_FFFF, 32'h0000_0005, 32'h0, 32'h0000_0004, 0, 0, 0, 0});
    vecs.push_back('{"beq",   32'h1000_0000, 32'h0000_0005, 32'h5, 32'h0000_0000, 1, 0, 0, 0});
    vecs.push_back('{"ill3f", 32'hFC00_0000, 32'h1111_1111, 32'h2, 32'h0000_0000, 0, 0, 0, 1});
    vecs.push_back('{"sub",   32'h0000_0022, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 0, 1, 1, 0});
    vecs.push_back('{"subu",  32'h0000_0023, 32'h0000_0003, 32'h3, 32'h0000_0000, 1, 0, 0, 0});
    vecs.push_back('{"or",    32'h0000_0025, 32'hF0F0_0000, 32'h0000_F0F0, 32'hF0F0_F0F0, 0, 0, 0, 0});
    vecs.push_back('{"nor",   32'h0000_0027, 32'hF0F0_0000, 32'h0000_F0F0, 32'h0F0F_0F0F, 0, 0, 0, 0});
    vecs.push_back('{"slt",   32'h0000_002A, 32'hFFFF_FFFF, 32'h1, 32'h0000_0001, 0, 0, 0, 0});
    vecs.push_back('{"slti",  32'h2800_FFFE, 32'h0000_0001, 32'h0, 32'h0000_0000, 1, 0, 0, 0});
    vecs.push_back('{"ori",   32'h3400_8001, 32'h0001_0000, 32'h0, 32'h0001_8001, 0, 0, 0, 0});
    vecs.push_back('{"addi",  32'h2000_8000, 32'h8000_0000, 32'h0, 32'h7FFF_8000, 0, 1, 1, 0});
    vecs.push_back('{"ill26", 32'h0000_0026, 32'h1, 32'h1, 32'h0000_0000, 0, 0, 0, 1});

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst.state", {30'd0, instr_ready, res_valid}, 32'd2);
    chk("rst.res", res_data | {28'd0, res_zero, res_overflow, res_trap, res_illegal}, 32'd0);
    chk("rst.alu", {27'd0, alu_cmd, 2'b00} | alu_a | alu_b, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Hold DONE for five cycles with res_ready low.
    @(negedge clk);
    instr = 32'h3400_8001; rs_val = 32'h0001_0000; instr_valid = 1'b1;
    repeat (3) @(negedge clk);
    instr_valid = 1'b0;
    held = res_data;
    chk("hold.data0", res_data, 32'h0001_8001);
    for (int k = 0; k < 5; k++) begin
      chk("hold.valid", {30'd0, res_valid, instr_ready}, 32'd2);
      chk("hold.data", res_data, held);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("hold.release", {30'd0, instr_ready, res_valid}, 32'd2);

    // Reset during WAIT of an add, then a clean addu.
    instr = 32'h0000_0020; rs_val = 32'h7FFF_FFFF; rt_val = 32'h1; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("wait.alu_cmd", 32'(alu_cmd), 32'(ADD));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw.state", {30'd0, instr_ready, res_valid}, 32'd2);
    chk("rstw.alu_cmd", 32'(alu_cmd), 32'(AND));
    va = '{"post_addu", 32'h0000_0021, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 1, 0, 0};
    run_vec(va);

    // Reset wins over a handshake in the same cycle.
    @(negedge clk);
    rst = 1'b1; instr_valid = 1'b1; instr = 32'h0000_0021;
    @(negedge clk);
    rst = 1'b0; instr_valid = 1'b0;
    chk("rst_prio", {30'd0, instr_ready, res_valid}, 32'd2);
    @(negedge clk);
    chk("rst_prio.alu", {27'd0, alu_cmd, 2'b00} | alu_a | alu_b, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
